// File: rtl/arbitro_escritura_registros.sv
// Write-port arbiter between the ALU and load writeback paths, plus a
// pending-write scoreboard that flags RAW/WAW hazards to the issue logic.
module arbitro_escritura_registros #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_dir,
  input  logic [DATA_W-1:0] alu_dato,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_dir,
  input  logic [DATA_W-1:0] mem_dato,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] iss_dir,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic              busy1,
  output logic              busy2,
  output logic              reg_write,
  output logic [ADDR_W-1:0] dir,
  output logic [DATA_W-1:0] di,
  output logic              grant_mem
);

  // last_q = 1 means the load path won the most recent transfer.
  logic              last_q, last_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] dir_q, dir_d;
  logic [DATA_W-1:0] di_q, di_d;
  logic              grant_mem_q, grant_mem_d;
  logic [NREG-1:0]   pend_q, pend_d;

  logic              alu_xfer, mem_xfer, xfer;
  logic [ADDR_W-1:0] w_dir;
  logic [DATA_W-1:0] w_dato;

  always_comb begin
    alu_ready = alu_valid && (!mem_valid || last_q);
    mem_ready = mem_valid && (!alu_valid || !last_q);
    alu_xfer  = alu_valid && alu_ready;
    mem_xfer  = mem_valid && mem_ready;
    xfer      = alu_xfer || mem_xfer;
    w_dir     = mem_xfer ? mem_dir  : alu_dir;
    w_dato    = mem_xfer ? mem_dato : alu_dato;
    iss_ready = !pend_q[iss_dir] || (iss_dir == '0);
    busy1     = pend_q[ra1] && (ra1 != '0);
    busy2     = pend_q[ra2] && (ra2 != '0);
  end

  always_comb begin
    last_d      = last_q;
    reg_write_d = 1'b0;
    dir_d       = dir_q;
    di_d        = di_q;
    grant_mem_d = grant_mem_q;
    pend_d      = pend_q;
    if (xfer) begin
      last_d      = mem_xfer;
      reg_write_d = (w_dir != '0);
      dir_d       = w_dir;
      di_d        = w_dato;
      grant_mem_d = mem_xfer;
      pend_d[w_dir] = 1'b0;
    end
    // Applied after the clear so a same-cycle issue keeps the register pending.
    if (iss_valid && iss_ready && (iss_dir != '0)) begin
      pend_d[iss_dir] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q      <= 1'b1;
      reg_write_q <= 1'b0;
      dir_q       <= '0;
      di_q        <= '0;
      grant_mem_q <= 1'b0;
      pend_q      <= '0;
    end else begin
      last_q      <= last_d;
      reg_write_q <= reg_write_d;
      dir_q       <= dir_d;
      di_q        <= di_d;
      grant_mem_q <= grant_mem_d;
      pend_q      <= pend_d;
    end
  end

  assign reg_write = reg_write_q;
  assign dir       = dir_q;
  assign di        = di_q;
  assign grant_mem = grant_mem_q;

endmodule

// File: tb/tb_arbitro_escritura_registros.sv
// Directed bench for arbitro_escritura_registros: arbitration, write latency,
// scoreboard set/clear and register-0 handling.
module tb_arbitro_escritura_registros;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              alu_valid, alu_ready;
  logic [ADDR_W-1:0] alu_dir;
  logic [DATA_W-1:0] alu_dato;
  logic              mem_valid, mem_ready;
  logic [ADDR_W-1:0] mem_dir;
  logic [DATA_W-1:0] mem_dato;
  logic              iss_valid, iss_ready;
  logic [ADDR_W-1:0] iss_dir, ra1, ra2;
  logic              busy1, busy2, reg_write, grant_mem;
  logic [ADDR_W-1:0] dir;
  logic [DATA_W-1:0] di;

  int n_vec = 0;
  int n_err = 0;

  arbitro_escritura_registros #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREG(32)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dir(alu_dir), .alu_dato(alu_dato),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dir(mem_dir), .mem_dato(mem_dato),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_dir(iss_dir),
    .ra1(ra1), .ra2(ra2), .busy1(busy1), .busy2(busy2),
    .reg_write(reg_write), .dir(dir), .di(di), .grant_mem(grant_mem)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; mem_valid = 1'b0; iss_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    alu_valid = 1'b1; alu_dir = 5'd3; alu_dato = '1;
    mem_valid = 1'b1; mem_dir = 5'd4; mem_dato = '1;
    iss_valid = 1'b1; iss_dir = 5'd3; ra1 = 5'd3; ra2 = 5'd4;
    tick();
    tick();
    reset = 1'b0;
    idle();
    #1;
    n_vec++; if (reg_write !== 1'b0) begin n_err++; $display("FAIL rst_reg_write got %b want 0", reg_write); end
    n_vec++; if (dir !== 5'd0) begin n_err++; $display("FAIL rst_dir got %0d want 0", dir); end
    n_vec++; if (di !== 32'd0) begin n_err++; $display("FAIL rst_di got %h want 0", di); end
    n_vec++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b%b want 00", busy1, busy2); end
    n_vec++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL rst_iss_ready got %b want 1", iss_ready); end
    n_vec++; if (grant_mem !== 1'b0) begin n_err++; $display("FAIL rst_grant_mem got %b want 0", grant_mem); end
  endtask

  task automatic test_alternate();
    logic [ADDR_W-1:0] exp_dir;
    logic              exp_mem;
    alu_valid = 1'b1; alu_dir = 5'd3; alu_dato = 32'hA3A3_0003;
    mem_valid = 1'b1; mem_dir = 5'd4; mem_dato = 32'hB4B4_0004;
    for (int i = 0; i < 4; i++) begin
      exp_mem = (i % 2) == 1;
      exp_dir = exp_mem ? 5'd4 : 5'd3;
      #1;
      n_vec++; if (alu_ready !== !exp_mem || mem_ready !== exp_mem) begin
        n_err++; $display("FAIL alt_ready[%0d] got alu=%b mem=%b want mem=%b", i, alu_ready, mem_ready, exp_mem);
      end
      tick();
      n_vec++; if (reg_write !== 1'b1 || dir !== exp_dir || grant_mem !== exp_mem) begin
        n_err++; $display("FAIL alt_write[%0d] got we=%b dir=%0d gm=%b want 1 %0d %b", i, reg_write, dir, grant_mem, exp_dir, exp_mem);
      end
      n_vec++; if (di !== (exp_mem ? 32'hB4B4_0004 : 32'hA3A3_0003)) begin
        n_err++; $display("FAIL alt_di[%0d] got %h", i, di);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_alu_single();
    alu_valid = 1'b1; alu_dir = 5'd5; alu_dato = 32'hDEAD_BEEF;
    #1;
    n_vec++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin n_err++; $display("FAIL single_ready got alu=%b mem=%b want 1 0", alu_ready, mem_ready); end
    tick();
    idle();
    n_vec++; if (reg_write !== 1'b1 || dir !== 5'd5 || grant_mem !== 1'b0) begin
      n_err++; $display("FAIL single_write got we=%b dir=%0d gm=%b want 1 5 0", reg_write, dir, grant_mem);
    end
    n_vec++; if (di !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_di got %h want deadbeef", di); end
    tick();
    n_vec++; if (reg_write !== 1'b0 || dir !== 5'd5 || di !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL single_hold got we=%b dir=%0d di=%h want 0 5 deadbeef", reg_write, dir, di);
    end
  endtask

  task automatic test_scoreboard();
    iss_valid = 1'b1; iss_dir = 5'd7; ra1 = 5'd7;
    #1;
    n_vec++; if (iss_ready !== 1'b1 || busy1 !== 1'b0) begin n_err++; $display("FAIL sb_issue got rdy=%b busy1=%b want 1 0", iss_ready, busy1); end
    tick();
    n_vec++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL sb_busy got %b want 1", busy1); end
    n_vec++; if (iss_ready !== 1'b0) begin n_err++; $display("FAIL sb_waw got %b want 0", iss_ready); end
    iss_valid = 1'b0;
    mem_valid = 1'b1; mem_dir = 5'd7; mem_dato = 32'h0000_0077;
    #1;
    n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL sb_mem_ready got %b want 1", mem_ready); end
    tick();
    idle();
    n_vec++; if (busy1 !== 1'b0 || iss_ready !== 1'b1) begin n_err++; $display("FAIL sb_clear got busy1=%b rdy=%b want 0 1", busy1, iss_ready); end
    n_vec++; if (reg_write !== 1'b1 || dir !== 5'd7 || grant_mem !== 1'b1) begin
      n_err++; $display("FAIL sb_write got we=%b dir=%0d gm=%b want 1 7 1", reg_write, dir, grant_mem);
    end
  endtask

  task automatic test_same_cycle();
    iss_valid = 1'b1; iss_dir = 5'd9; ra2 = 5'd9;
    alu_valid = 1'b1; alu_dir = 5'd9; alu_dato = 32'h0000_0099;
    #1;
    n_vec++; if (alu_ready !== 1'b1 || iss_ready !== 1'b1) begin n_err++; $display("FAIL same_ready got alu=%b iss=%b want 1 1", alu_ready, iss_ready); end
    tick();
    idle();
    n_vec++; if (busy2 !== 1'b1) begin n_err++; $display("FAIL same_pend got busy2=%b want 1", busy2); end
    n_vec++; if (reg_write !== 1'b1 || dir !== 5'd9 || di !== 32'h0000_0099) begin
      n_err++; $display("FAIL same_write got we=%b dir=%0d di=%h want 1 9 99", reg_write, dir, di);
    end
    alu_valid = 1'b1;
    tick();
    idle();
    n_vec++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL same_clear got busy2=%b want 0", busy2); end
  endtask

  task automatic test_reg_zero();
    // Load win first so the dir-0 ALU transfer must move the pointer back.
    mem_valid = 1'b1; mem_dir = 5'd10; mem_dato = 32'h0000_0010;
    tick();
    idle();
    alu_valid = 1'b1; alu_dir = 5'd0; alu_dato = 32'h0000_0001;
    iss_valid = 1'b1; iss_dir = 5'd0; ra1 = 5'd0;
    #1;
    n_vec++; if (alu_ready !== 1'b1 || iss_ready !== 1'b1) begin n_err++; $display("FAIL zero_ready got alu=%b iss=%b want 1 1", alu_ready, iss_ready); end
    tick();
    idle();
    n_vec++; if (reg_write !== 1'b0) begin n_err++; $display("FAIL zero_we got %b want 0", reg_write); end
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL zero_busy got %b want 0", busy1); end
    alu_valid = 1'b1; alu_dir = 5'd3; mem_valid = 1'b1; mem_dir = 5'd4;
    #1;
    n_vec++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
      n_err++; $display("FAIL zero_ptr got alu=%b mem=%b want 0 1", alu_ready, mem_ready);
    end
    tick();
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    alu_dir = '0; alu_dato = '0; mem_dir = '0; mem_dato = '0;
    iss_dir = '0; ra1 = '0; ra2 = '0;
    test_reset();
    test_alternate();
    test_alu_single();
    test_scoreboard();
    test_same_cycle();
    test_reg_zero();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
